gnss_code_mem: RTL and testbench



---
 rtl/gnss_code_pkg.sv | 31 +++
 rtl/gnss_code_ram.sv | 25 ++
 rtl/gnss_code_mem.sv | 158 +++++++++++++++
 tb/tb_gnss_code_mem.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gnss_code_pkg.sv
// Shared widths and helpers for the multi-bank GNSS spreading-code memory.
package gnss_code_pkg;

    // Default chip-index and bank-select widths (12-bit chips, 2 banks)
    localparam int CHIP_W_DEF = 12;
    localparam int BANK_W_DEF = 1;

    // Ceiling log2 for elaboration-time width calculations
    function automatic int clog2(input int unsigned v);
        int r;
        r = 0;
        for (int i = 0; i < 32; i++) begin
            if ((64'd1 << i) < 64'(v)) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

    // Index width that never collapses to zero bits
    function automatic int idx_w(input int unsigned n);
        return (clog2(n) > 1) ? clog2(n) : 1;
    endfunction

    // Chip that follows n in a code of length len; anything at or past the
    // last chip (including out-of-range indices) restarts at chip 0
    function automatic int unsigned next_chip(input int unsigned n, input int unsigned len);
        return (n >= len - 1) ? 32'd0 : n + 32'd1;
    endfunction

endpackage

// File: rtl/gnss_code_ram.sv
// Simple-dual-port code RAM with registered read; read-first on collision.
module gnss_code_ram #(
    parameter int WIDTH = 12,
    parameter int AW    = 13,
    parameter int DEPTH = 1 << AW
) (
    input  logic             clk,
    input  logic             we_i,
    input  logic [AW-1:0]    waddr_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic [AW-1:0]    raddr_i,
    output logic [WIDTH-1:0] rdata_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    // One write port, one registered read port; a same-address read sees old data
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
        rdata_o <= mem_q[raddr_i];
    end

endmodule

// File: rtl/gnss_code_mem.sv
// Multi-bank spreading-code memory: CPU-loaded banks, per-channel bank select
// and code length, time-multiplexed chip prefetch, chip-boundary consumers.
module gnss_code_mem
    import gnss_code_pkg::*;
#(
    parameter int CHANS    = 12,
    parameter int CODEBITS = CHIP_W_DEF,
    parameter int NBANKS   = 2,
    parameter int BANKBITS = idx_w(NBANKS),
    parameter int CODELEN  = 4092
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         wr,
    input  logic [CHANS-1:0]             wdata,
    input  logic                         ptr_wr,
    input  logic [BANKBITS+CODEBITS-1:0] ptr_data,
    input  logic                         len_wr,
    input  logic [BANKBITS-1:0]          len_bank,
    input  logic [CODEBITS:0]            len_data,
    input  logic                         bsel_wr,
    input  logic [idx_w(CHANS)-1:0]      bsel_ch,
    input  logic [BANKBITS-1:0]          bsel_data,
    input  logic [CHANS*CODEBITS-1:0]    nchip_n,
    input  logic [CHANS-1:0]             full_chip,
    output logic [CHANS-1:0]             code_o
);

    localparam int AW   = BANKBITS + CODEBITS;
    localparam int RAW  = CODEBITS + clog2(NBANKS);
    localparam int CHW  = idx_w(CHANS);
    localparam int LENW = CODEBITS + 1;
    localparam logic [LENW-1:0] FULL_LEN = {1'b1, {CODEBITS{1'b0}}};
    localparam logic [LENW-1:0] RST_LEN  = LENW'(CODELEN);

    // Write pointer and configuration
    logic [AW-1:0]       waddr_q, waddr_d;
    logic [LENW-1:0]     len_q  [NBANKS];
    logic [BANKBITS-1:0] bsel_q [CHANS];
    logic [LENW-1:0]     len_store;

    // Producer pipeline
    logic [CHW-1:0]      ch_p0_q;
    logic [BANKBITS-1:0] bank_p0;
    logic [CODEBITS-1:0] n_p0, nxt_p0;
    logic [AW-1:0]       raddr_p1_q;
    logic [CHW-1:0]      tag_p1_q, tag_p2_q;
    logic                vld_p1_q, vld_p2_q;
    logic [CHANS-1:0]    dout_p2;

    // Prefetched and presented chips
    logic [CHANS-1:0]    code_n_q;
    logic [CHANS-1:0]    code_q;

    // Post-increment on write; an explicit pointer load overrides the increment
    always_comb begin
        waddr_d = waddr_q;
        if (wr) begin
            waddr_d = waddr_q + AW'(1);
        end
        if (ptr_wr) begin
            waddr_d = ptr_data;
        end
    end

    // Zero (or anything too large) encodes the full bank depth
    always_comb begin
        len_store = len_data;
        if ((len_data == '0) || (len_data > FULL_LEN)) begin
            len_store = FULL_LEN;
        end
    end

    // Write pointer and per-bank / per-channel configuration registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            waddr_q <= '0;
            for (int b = 0; b < NBANKS; b++) begin
                len_q[b] <= RST_LEN;
            end
            for (int c = 0; c < CHANS; c++) begin
                bsel_q[c] <= '0;
            end
        end else begin
            waddr_q <= waddr_d;
            if (len_wr && (32'(len_bank) < NBANKS)) begin
                len_q[len_bank] <= len_store;
            end
            if (bsel_wr && (32'(bsel_ch) < CHANS)) begin
                bsel_q[bsel_ch] <= bsel_data;
            end
        end
    end

    // ---- S0: pick the scanned channel's bank and next chip ----
    always_comb begin
        bank_p0 = bsel_q[ch_p0_q];
        n_p0    = nchip_n[int'(ch_p0_q)*CODEBITS +: CODEBITS];
        nxt_p0  = CODEBITS'(next_chip(32'(n_p0), 32'(len_q[bank_p0])));
    end

    // Read address is pure data and carries no reset
    always_ff @(posedge clk) begin
        raddr_p1_q <= {bank_p0, nxt_p0};
    end

    // ---- S1: RAM read in flight; channel tag and valid follow the data ----
    gnss_code_ram #(
        .WIDTH (CHANS),
        .AW    (RAW),
        .DEPTH (NBANKS << CODEBITS)
    ) u_ram (
        .clk     (clk),
        .we_i    (wr),
        .waddr_i (waddr_q[RAW-1:0]),
        .wdata_i (wdata),
        .raddr_i (raddr_p1_q[RAW-1:0]),
        .rdata_o (dout_p2)
    );

    // Scan counter and tag/valid pipeline
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ch_p0_q  <= '0;
            tag_p1_q <= '0;
            vld_p1_q <= 1'b0;
            tag_p2_q <= '0;
            vld_p2_q <= 1'b0;
        end else begin
            ch_p0_q  <= (ch_p0_q == CHW'(CHANS - 1)) ? '0 : ch_p0_q + CHW'(1);
            tag_p1_q <= ch_p0_q;
            vld_p1_q <= 1'b1;
            tag_p2_q <= tag_p1_q;
            vld_p2_q <= vld_p1_q;
        end
    end

    // ---- S2: deposit the tagged channel's bit into its prefetch slot ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            code_n_q <= '0;
        end else if (vld_p2_q) begin
            code_n_q[tag_p2_q] <= dout_p2[tag_p2_q];
        end
    end

    // Each consumer latches its prefetched chip at its own chip boundary
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            code_q <= '0;
        end else begin
            code_q <= (full_chip & code_n_q) | (~full_chip & code_q);
        end
    end

    assign code_o = code_q;

endmodule

// File: tb/tb_gnss_code_mem.sv
// Scoreboard bench for gnss_code_mem with a behavioural memory/config model.
module tb_gnss_code_mem;

    localparam int CH      = 12;
    localparam int CB      = 12;
    localparam int NB      = 2;
    localparam int BB      = 1;
    localparam int AW      = BB + CB;
    localparam int CHW     = 4;
    localparam int CODELEN = 4092;
    localparam int BANKSZ  = 1 << CB;
    localparam int MEMSZ   = 1 << AW;

    logic                clk = 1'b0;
    logic                rst_n = 1'b1;
    logic                wr = 1'b0;
    logic [CH-1:0]       wdata = '0;
    logic                ptr_wr = 1'b0;
    logic [AW-1:0]       ptr_data = '0;
    logic                len_wr = 1'b0;
    logic [BB-1:0]       len_bank = '0;
    logic [CB:0]         len_data = '0;
    logic                bsel_wr = 1'b0;
    logic [CHW-1:0]      bsel_ch = '0;
    logic [BB-1:0]       bsel_data = '0;
    logic [CH*CB-1:0]    nchip_n = '0;
    logic [CH-1:0]       full_chip = '0;
    logic [CH-1:0]       code_o;

    always #5 clk = ~clk;

    gnss_code_mem dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .wr        (wr),
        .wdata     (wdata),
        .ptr_wr    (ptr_wr),
        .ptr_data  (ptr_data),
        .len_wr    (len_wr),
        .len_bank  (len_bank),
        .len_data  (len_data),
        .bsel_wr   (bsel_wr),
        .bsel_ch   (bsel_ch),
        .bsel_data (bsel_data),
        .nchip_n   (nchip_n),
        .full_chip (full_chip),
        .code_o    (code_o)
    );

    // Behavioural model: flat memory, per-bank lengths, per-channel selects
    logic [CH-1:0] m_mem [0:MEMSZ-1];
    int            m_len  [NB];
    int            m_bsel [CH];
    int            m_nchip[CH];
    int            m_waddr;
    logic [CH-1:0] m_code;
    logic [CH-1:0] exp_q [$];

    int checks = 0;
    int errors = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        m_waddr = 0;
        for (int b = 0; b < NB; b++) m_len[b] = CODELEN;
        for (int c = 0; c < CH; c++) m_bsel[c] = 0;
        m_code = '0;
        exp_q.delete();
    endtask

    task automatic do_wr(input logic [CH-1:0] d);
        wr = 1'b1; wdata = d;
        tick();
        wr = 1'b0;
        m_mem[m_waddr] = d;
        m_waddr = (m_waddr + 1) % MEMSZ;
    endtask

    task automatic do_ptr(input int p);
        ptr_wr = 1'b1; ptr_data = AW'(p);
        tick();
        ptr_wr = 1'b0;
        m_waddr = p;
    endtask

    task automatic do_ptr_wr(input int p, input logic [CH-1:0] d);
        ptr_wr = 1'b1; ptr_data = AW'(p); wr = 1'b1; wdata = d;
        tick();
        ptr_wr = 1'b0; wr = 1'b0;
        m_mem[m_waddr] = d;
        m_waddr = p;
    endtask

    task automatic do_len(input int b, input int l);
        len_wr = 1'b1; len_bank = BB'(b); len_data = (CB+1)'(l);
        tick();
        len_wr = 1'b0;
        m_len[b] = (l == 0) ? BANKSZ : l;
    endtask

    task automatic do_bsel(input int c, input int b);
        bsel_wr = 1'b1; bsel_ch = CHW'(c); bsel_data = BB'(b);
        tick();
        bsel_wr = 1'b0;
        m_bsel[c] = b;
    endtask

    task automatic set_nchip(input int c, input int n);
        nchip_n[c*CB +: CB] = CB'(n);
        m_nchip[c] = n;
    endtask

    task automatic set_all_nchip(input int n);
        for (int c = 0; c < CH; c++) set_nchip(c, n);
    endtask

    task automatic settle();
        repeat (CH + 4) tick();
    endtask

    // Chip a channel should present: the one after its current chip, in its
    // own bank, wrapping at that bank's length; out-of-range chips restart at 0
    function automatic logic m_chip(input int c);
        int b, len, n, nx;
        b   = m_bsel[c];
        len = m_len[b];
        n   = m_nchip[c];
        nx  = (n >= len) ? 0 : (n + 1) % len;
        return m_mem[b*BANKSZ + nx][c];
    endfunction

    task automatic pulse(input logic [CH-1:0] m);
        for (int i = 0; i < CH; i++) begin
            if (m[i]) m_code[i] = m_chip(i);
        end
        exp_q.push_back(m_code);
        full_chip = m;
        tick();
        full_chip = '0;
    endtask

    // Monitor: a full_chip edge makes the DUT present a new code_o
    logic          fc_seen = 1'b0;
    logic [CH-1:0] exp_cur = '0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) fc_seen <= 1'b0;
        else        fc_seen <= |full_chip;
    end

    always @(negedge clk) begin
        if (!rst_n) begin
            exp_cur = '0;
        end else if (fc_seen) begin
            if (exp_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL scoreboard_underflow t=%0t code_o %h with no expectation", $time, code_o);
            end else begin
                exp_cur = exp_q.pop_front();
            end
        end
        checks++;
        if (code_o !== exp_cur) begin
            errors++;
            $display("FAIL code_o t=%0t actual %h required %h", $time, code_o, exp_cur);
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog t=%0t bench did not finish", $time);
        $fatal(1, "timeout");
    end

    initial begin
        logic [CH-1:0] w;
        model_reset();
        for (int c = 0; c < CH; c++) m_nchip[c] = 0;
        #1 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #3 rst_n = 1'b1;
        tick();

        // Bank 0 gets word k = k; every channel sits on chip 5
        set_all_nchip(5);
        for (int k = 0; k < CODELEN; k++) begin
            w = CH'(k);
            do_wr(w);
        end
        repeat (20) tick();
        pulse('1);

        // Last chip wraps to 0; shortened code wraps early; out-of-range restarts
        set_all_nchip(4091);
        settle(); pulse('1);
        do_len(0, 1023);
        set_all_nchip(1022);
        settle(); pulse('1);
        set_all_nchip(2000);
        settle(); pulse('1);

        // Bank 1 gets the inverted pattern; only channel 3 moves to it
        do_ptr(BANKSZ);
        for (int k = 0; k < BANKSZ; k++) begin
            w = CH'(k);
            do_wr(~w);
        end
        set_all_nchip(5);
        settle(); pulse('1);
        do_bsel(3, 1);
        settle(); pulse('1);

        // Pointer at the top of bank 1 wraps into bank 0; combined ptr+wr
        do_ptr(MEMSZ - 1);
        do_wr(12'hABC);
        do_wr(12'h123);
        do_wr(12'h5A5);
        do_ptr_wr(BANKSZ + 10, 12'h3C3);
        do_wr(12'h0F0);
        do_len(1, 0);
        do_bsel(0, 1); set_nchip(0, 4094);
        set_nchip(1, 1022);
        set_nchip(2, 0);
        set_nchip(4, 1);
        do_bsel(5, 1); set_nchip(5, BANKSZ + 9 - BANKSZ);
        settle(); pulse('1);
        set_all_nchip(5);
        settle(); pulse('1);

        // Reset while reloading bank 0, between clock edges
        do_ptr(0);
        for (int k = 0; k < CODELEN; k++) begin
            if (k == 1000) begin
                #2;
                rst_n = 1'b0;
                model_reset();
                #1;
                checks++;
                if (code_o !== '0) begin
                    errors++;
                    $display("FAIL async_reset_code actual %h required %h", code_o, {CH{1'b0}});
                end
                repeat (3) @(posedge clk);
                #3 rst_n = 1'b1;
                tick();
                break;
            end
            w = CH'(k);
            do_wr(w);
        end

        // Defaults restored: bank 0 for everyone, length 4092, pointer 0
        set_all_nchip(5);
        repeat (20) tick();
        pulse('1);
        set_all_nchip(2000);
        settle(); pulse('1);
        do_wr(12'hA5C);
        set_all_nchip(4091);
        settle(); pulse('1);

        // Fill the tail of bank 0 so every address is known
        do_ptr(CODELEN);
        for (int k = 0; k < BANKSZ - CODELEN; k++) do_wr(CH'($urandom));

        // Randomised soak
        for (int it = 0; it < 300; it++) begin
            int r;
            r = $urandom_range(0, 9);
            if (r == 0) do_len($urandom_range(0, NB-1), $urandom_range(0, BANKSZ));
            if (r == 1) do_len($urandom_range(0, NB-1), $urandom_range(1, 20));
            if (r == 2 || r == 3) do_bsel($urandom_range(0, CH-1), $urandom_range(0, NB-1));
            if (r == 4) begin
                do_ptr($urandom_range(0, MEMSZ-1));
                repeat (3) do_wr(CH'($urandom));
            end
            for (int c = 0; c < CH; c++) begin
                int l;
                l = m_len[m_bsel[c]];
                case ($urandom_range(0, 3))
                    0:       set_nchip(c, l - 1);
                    1:       set_nchip(c, (l < BANKSZ) ? l : 0);
                    default: set_nchip(c, $urandom_range(0, BANKSZ-1));
                endcase
            end
            settle();
            pulse(CH'($urandom_range(1, (1 << CH) - 1)));
        end

        repeat (4) tick();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain actual %0d pending required 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
